control_word_issue: RTL

//  Receiving end of the decoder interface. Takes {controlWord, nextState, K} from the
//  per-class decode logic, owns the 2-bit sequencer state register fed back to decode,

---
 rtl/cw_pkg.sv | 57 +++++
 rtl/control_word_issue_if.sv | 22 ++
 rtl/cw_skid_buf.sv | 49 ++++
 rtl/control_word_issue.sv | 91 +++++++++
 4 files changed

// File: rtl/cw_pkg.sv
// Shared types, widths and field positions for the control-word issue stage.
// Field positions follow the decoder's control-word layout, MSB first.
package cw_pkg;

  localparam int CW_W = 31;
  localparam int K_W  = 64;
  localparam int ST_W = 2;

  localparam int PSEL_HI  = 30;
  localparam int PSEL_LO  = 29;
  localparam int DA_HI    = 28;
  localparam int DA_LO    = 24;
  localparam int SA_HI    = 23;
  localparam int SA_LO    = 19;
  localparam int SB_HI    = 18;
  localparam int SB_LO    = 14;
  localparam int FSEL_HI  = 13;
  localparam int FSEL_LO  = 9;
  localparam int REGW_B   = 8;
  localparam int RAMW_B   = 7;
  localparam int ENMEM_B  = 6;
  localparam int ENALU_B  = 5;
  localparam int ENB_B    = 4;
  localparam int ENPC_B   = 3;
  localparam int BSEL_B   = 2;
  localparam int PCSEL_B  = 1;
  localparam int SL_B     = 0;

  localparam logic [CW_W-1:0] CW_NOP = '0;
  localparam logic [4:0]      REG_ZR = 5'd31;

  typedef enum logic [ST_W-1:0] {
    ST_FETCH = 2'b00,
    ST_EX1   = 2'b01,
    ST_EX2   = 2'b10,
    ST_EX3   = 2'b11
  } seq_state_e;

  function automatic logic [4:0] cw_da(
    input logic [CW_W-1:0] cw
  );
    return cw[DA_HI:DA_LO];
  endfunction

  function automatic logic [4:0] cw_sa(
    input logic [CW_W-1:0] cw
  );
    return cw[SA_HI:SA_LO];
  endfunction

  function automatic logic [4:0] cw_sb(
    input logic [CW_W-1:0] cw
  );
    return cw[SB_HI:SB_LO];
  endfunction

endpackage

// File: rtl/control_word_issue_if.sv
// Valid/ready channel carrying a control word, constant and next state.
// master drives the payload, slave returns ready.
interface control_word_issue_if;
  import cw_pkg::*;

  logic            valid;
  logic            ready;
  logic [CW_W-1:0] cw;
  logic [K_W-1:0]  k;
  logic [ST_W-1:0] next;

  modport master (
    output valid, cw, k, next,
    input  ready
  );

  modport slave (
    input  valid, cw, k, next,
    output ready
  );

endinterface

// File: rtl/cw_skid_buf.sv
// Output register plus one-entry skid buffer, generic payload width.
// Skid always drains before new words; ordering is strictly FIFO.
module cw_skid_buf #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] in_data,
  input  logic         pop,
  output logic         skid_empty,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         out_free;

  assign out_free   = ~out_valid | pop;
  assign skid_empty = ~skid_valid;

  // move skid->out first, else route a pushed word to out or skid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (skid_valid) begin
      if (out_free) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (push) begin
      if (out_free) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/control_word_issue.sv
// Issue stage: owns sequencer state, buffers decode words, counts bubbles.
// Optional RAW interlock against the output word: `define HAZARD_STALL_EN.
module control_word_issue
  import cw_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  control_word_issue_if.slave  dec,
  control_word_issue_if.master dp,
  output logic [ST_W-1:0]      state,
  output logic [15:0]          bubbles
);

  logic                  hold;
  logic                  accept;
  logic                  skid_empty;
  logic                  out_valid;
  logic [CW_W+K_W-1:0]   out_data;
  logic [CW_W-1:0]       out_cw;
  seq_state_e            state_q;
  logic                  started;
  logic                  idle;

  assign out_cw = out_data[CW_W+K_W-1:K_W];

`ifdef HAZARD_STALL_EN
  logic consumer;
  logic producer;
  logic sa_hit;
  logic sb_hit;

  assign consumer = dec.cw[REGW_B] | dec.cw[SL_B];
  assign producer = out_valid & out_cw[REGW_B]
                  & (cw_da(out_cw) != REG_ZR);
  assign sa_hit   = cw_sa(dec.cw) == cw_da(out_cw);
  assign sb_hit   = ~dec.cw[BSEL_B]
                  & (cw_sb(dec.cw) == cw_da(out_cw));
  assign hold     = consumer & producer & (sa_hit | sb_hit);
`else
  assign hold = 1'b0;
`endif

  assign dec.ready = skid_empty & ~hold;
  assign accept    = dec.valid & dec.ready;

  cw_skid_buf #(
    .W (CW_W + K_W)
  ) u_skid (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (accept),
    .in_data    ({dec.cw, dec.k}),
    .pop        (dp.ready),
    .skid_empty (skid_empty),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

  assign dp.valid = out_valid;
  assign dp.cw    = out_valid ? out_cw : CW_NOP;
  assign dp.k     = out_data[K_W-1:0];
  assign dp.next  = state;
  assign state    = state_q;

  // sequencer state follows decode only on an accepted word
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
    end else if (accept) begin
      state_q <= seq_state_e'(dec.next);
    end
  end

  assign idle = started & dp.ready & ~out_valid;

  // saturating count of empty slots offered to a ready datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      started <= 1'b0;
      bubbles <= '0;
    end else begin
      if (accept) begin
        started <= 1'b1;
      end
      if (idle && bubbles != 16'hFFFF) begin
        bubbles <= bubbles + 16'd1;
      end
    end
  end

endmodule
